// File: rtl/uart_tx_cfg_fifo_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the configurable UART transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int NBITS_MIN = 5;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'(NBITS_MIN))
      return 4'(NBITS_MIN);
    else if (req > max_bits)
      return max_bits;
    else
      return req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_cfg_fifo_if.sv
// ============================================================================
// uart_tx_cfg_fifo_if : peripheral-bus side config/write/status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_cfg_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 5,
  parameter int BAUD_W  = 16
);

  logic [BAUD_W-1:0]  baud_div_i;
  logic [3:0]         nbits_i;
  logic [1:0]         parity_i;
  logic               stop2_i;
  logic               tx_en_i;
  logic               wr_en_i;
  logic [DATA_W-1:0]  wdata_i;
  logic               ovf_clr_i;

  logic               full_o;
  logic               empty_o;
  logic [FIFO_AW:0]   level_o;
  logic               overflow_o;
  logic               busy_o;
  logic               tx_done_tick_o;

  modport master (
    output baud_div_i, nbits_i, parity_i, stop2_i, tx_en_i, wr_en_i, wdata_i, ovf_clr_i,
    input  full_o, empty_o, level_o, overflow_o, busy_o, tx_done_tick_o
  );

  modport slave (
    input  baud_div_i, nbits_i, parity_i, stop2_i, tx_en_i, wr_en_i, wdata_i, ovf_clr_i,
    output full_o, empty_o, level_o, overflow_o, busy_o, tx_done_tick_o
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_cfg_fifo_fifo.sv
// ============================================================================
// uart_sync_fifo : single-clock FIFO, first-word-fall-through, registered flags
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 5
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_push,
  input  wire logic [DATA_W-1:0]  i_wdata,
  input  wire logic               i_pop,
  output logic      [DATA_W-1:0]  o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic      [FIFO_AW:0]   o_level
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [FIFO_AW:0]   w_level_nxt;
  logic               r_full;
  logic               r_empty;
  logic               w_push;
  logic               w_pop;

  // Qualifiers use the registered flags, so a full FIFO refuses a push even if it pops this cycle.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop)
      w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg_fifo.sv
// ============================================================================
// uart_tx_cfg_fifo : UART transmitter with TX FIFO and per-frame runtime config
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_cfg_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 5,
  parameter int BAUD_W  = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          cts_n_i,
  output logic               tx_o,
  uart_tx_cfg_fifo_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;
  localparam logic [3:0] NB_MAX    = 4'(DATA_W);

  logic [DATA_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [FIFO_AW:0]   w_level;
  logic               w_start;
  logic               w_load;
  logic               w_bit_end;
  logic               w_last_stop;
  logic               w_line;
  logic               w_reject;

  logic [2:0]         r_state;
  logic [BAUD_W-1:0]  r_cnt;
  logic [BAUD_W-1:0]  r_div;
  logic [3:0]         r_nbits;
  logic [3:0]         r_bitidx;
  logic [DATA_W-1:0]  r_shift;
  logic               r_par_en;
  logic               r_par_odd;
  logic               r_par_acc;
  logic               r_stop2;
  logic               r_tx;
  logic               r_done;
  logic               r_ovf;

  uart_sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (bus.wr_en_i),
    .i_wdata (bus.wdata_i),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_start     = bus.tx_en_i && !cts_n_i && !w_empty;
  assign w_bit_end   = (r_cnt == r_div - 1'b1);
  assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bitidx == {3'b000, r_stop2});
  assign w_load      = w_start && ((r_state == ST_IDLE) || w_last_stop);
  assign w_reject    = bus.wr_en_i && w_full;

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_par_acc ^ r_par_odd;
      default:   w_line = 1'b1;
    endcase
  end

  // The line and done tick are registered from state, so they trail it by one cycle together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_nbits   <= 4'(NBITS_MIN);
      r_bitidx  <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_par_acc <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_tx   <= w_line;
      r_done <= w_last_stop;
      if (w_load) begin
        r_state   <= ST_START;
        r_cnt     <= '0;
        r_div     <= (bus.baud_div_i == '0) ? BAUD_W'(1) : bus.baud_div_i;
        r_nbits   <= clamp_nbits(bus.nbits_i, NB_MAX);
        r_par_en  <= (bus.parity_i == PAR_EVEN) || (bus.parity_i == PAR_ODD);
        r_par_odd <= (bus.parity_i == PAR_ODD);
        r_stop2   <= bus.stop2_i;
        r_shift   <= w_head;
        r_par_acc <= 1'b0;
        r_bitidx  <= '0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          case (r_state)
            ST_START: begin
              r_state  <= ST_DATA;
              r_bitidx <= '0;
            end
            ST_DATA: begin
              r_par_acc <= r_par_acc ^ r_shift[0];
              r_shift   <= r_shift >> 1;
              if (r_bitidx == r_nbits - 1'b1) begin
                r_bitidx <= '0;
                r_state  <= r_par_en ? ST_PARITY : ST_STOP;
              end else begin
                r_bitidx <= r_bitidx + 1'b1;
              end
            end
            ST_PARITY: begin
              r_state  <= ST_STOP;
              r_bitidx <= '0;
            end
            ST_STOP: begin
              if (r_bitidx == {3'b000, r_stop2})
                r_state <= ST_IDLE;
              else
                r_bitidx <= r_bitidx + 1'b1;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Sticky overflow: a rejected write outranks a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_ovf <= 1'b0;
    else if (w_reject)
      r_ovf <= 1'b1;
    else if (bus.ovf_clr_i)
      r_ovf <= 1'b0;
  end

  assign tx_o               = r_tx;
  assign bus.full_o         = w_full;
  assign bus.empty_o        = w_empty;
  assign bus.level_o        = w_level;
  assign bus.overflow_o     = r_ovf;
  assign bus.busy_o         = (r_state != ST_IDLE);
  assign bus.tx_done_tick_o = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg_fifo.sv
// ============================================================================
// tb_uart_tx_cfg_fifo : directed self-checking bench for uart_tx_cfg_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg_fifo;

  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 5;
  localparam int BAUD_W  = 16;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic cts_n_i = 1'b0;
  logic tx_o;

  int checks   = 0;
  int failures = 0;

  uart_tx_cfg_fifo_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .BAUD_W(BAUD_W)) bus ();

  uart_tx_cfg_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW),
    .BAUD_W  (BAUD_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cts_n_i (cts_n_i),
    .tx_o    (tx_o),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en_i = 1'b1;
    bus.wdata_i = d;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wait_low(input string tag, input int limit);
    int n;
    n = 0;
    while (tx_o !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_o), 32'd0);
  endtask

  // Entered in the first cycle of the start bit; symbol s of the line is sym[s].
  task automatic run_frame(input string tag, input logic [15:0] sym, input int nsym, input int div);
    int d, bad, dones, done_last;
    d = (div == 0) ? 1 : div;
    dones = 0;
    done_last = 0;
    for (int s = 0; s < nsym; s++) begin
      bad = 0;
      for (int c = 0; c < d; c++) begin
        if (tx_o !== sym[s]) bad++;
        if (bus.tx_done_tick_o === 1'b1) begin
          dones++;
          if (s == nsym - 1 && c == d - 1) done_last = 1;
        end
        tick();
      end
      check($sformatf("%s_sym%0d", tag, s), 32'(bad), 32'd0);
    end
    check({tag, "_done_cnt"}, 32'(dones), 32'd1);
    check({tag, "_done_pos"}, 32'(done_last), 32'd1);
  endtask

  initial begin
    int lows;
    logic [7:0] d;

    bus.baud_div_i = 16'd4;
    bus.nbits_i    = 4'd8;
    bus.parity_i   = 2'b00;
    bus.stop2_i    = 1'b0;
    bus.tx_en_i    = 1'b1;
    bus.wr_en_i    = 1'b0;
    bus.wdata_i    = 8'h00;
    bus.ovf_clr_i  = 1'b0;

    // T1: asynchronous reset taking effect between edges
    #12 rst_i = 1'b1;
    #1;
    check("t1_tx", 32'(tx_o), 32'd1);
    check("t1_busy", 32'(bus.busy_o), 32'd0);
    check("t1_empty", 32'(bus.empty_o), 32'd1);
    check("t1_full", 32'(bus.full_o), 32'd0);
    check("t1_level", 32'(bus.level_o), 32'd0);
    check("t1_ovf", 32'(bus.overflow_o), 32'd0);
    check("t1_done", 32'(bus.tx_done_tick_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // T2: 8N1, div 4, 0xA5, latency write edge N -> start bit at N+2
    bus.wr_en_i = 1'b1;
    bus.wdata_i = 8'hA5;
    tick();
    bus.wr_en_i = 1'b0;
    check("t2_tx_n", 32'(tx_o), 32'd1);
    check("t2_level_n", 32'(bus.level_o), 32'd1);
    tick();
    check("t2_tx_n1", 32'(tx_o), 32'd1);
    check("t2_busy_n1", 32'(bus.busy_o), 32'd1);
    check("t2_empty_n1", 32'(bus.empty_o), 32'd1);
    tick();
    check("t2_tx_n2", 32'(tx_o), 32'd0);
    run_frame("t2", 16'h034A, 10, 4);
    check("t2_idle_tx", 32'(tx_o), 32'd1);
    check("t2_idle_busy", 32'(bus.busy_o), 32'd0);

    // T3: 7E2 at div 2, config changed mid-frame must not leak in; then 5O1 with clamped nbits, div 0
    bus.baud_div_i = 16'd2;
    bus.nbits_i    = 4'd7;
    bus.parity_i   = 2'b01;
    bus.stop2_i    = 1'b1;
    push(8'h53);
    wait_low("t3a_start", 6);
    bus.baud_div_i = 16'd0;
    bus.nbits_i    = 4'd3;
    bus.parity_i   = 2'b10;
    bus.stop2_i    = 1'b0;
    run_frame("t3a", 16'h06A6, 11, 2);
    push(8'h13);
    wait_low("t3b_start", 6);
    run_frame("t3b", 16'h00A6, 8, 0);
    tick();

    // T4: fill, overflow, set-wins, clear, then drain back-to-back
    bus.tx_en_i = 1'b0;
    bus.wr_en_i = 1'b1;
    for (int i = 0; i < 33; i++) begin
      bus.wdata_i = 8'(i * 37 + 5);
      tick();
      if (i == 30) begin
        check("t4_full_31", 32'(bus.full_o), 32'd0);
        check("t4_level_31", 32'(bus.level_o), 32'd31);
      end
    end
    bus.wr_en_i = 1'b0;
    check("t4_full", 32'(bus.full_o), 32'd1);
    check("t4_level", 32'(bus.level_o), 32'd32);
    check("t4_ovf", 32'(bus.overflow_o), 32'd1);
    check("t4_empty", 32'(bus.empty_o), 32'd0);
    bus.wr_en_i   = 1'b1;
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.wr_en_i   = 1'b0;
    check("t4_set_wins", 32'(bus.overflow_o), 32'd1);
    check("t4_level_hold", 32'(bus.level_o), 32'd32);
    tick();
    bus.ovf_clr_i = 1'b0;
    check("t4_ovf_clr", 32'(bus.overflow_o), 32'd0);
    bus.baud_div_i = 16'd1;
    bus.nbits_i    = 4'd8;
    bus.parity_i   = 2'b11;
    bus.stop2_i    = 1'b0;
    bus.tx_en_i    = 1'b1;
    wait_low("t4_start", 6);
    for (int i = 0; i < 32; i++) begin
      d = 8'(i * 37 + 5);
      run_frame($sformatf("t4_f%0d", i), 16'h0200 | (16'(d) << 1), 10, 1);
      if (i < 31) check($sformatf("t4_gap%0d", i), 32'(tx_o), 32'd0);
    end
    check("t4_end_empty", 32'(bus.empty_o), 32'd1);
    check("t4_end_level", 32'(bus.level_o), 32'd0);
    check("t4_end_busy", 32'(bus.busy_o), 32'd0);
    check("t4_end_tx", 32'(tx_o), 32'd1);

    // T5: CTS gates frame start only
    bus.baud_div_i = 16'd2;
    cts_n_i = 1'b1;
    push(8'h3C);
    push(8'hC3);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_o !== 1'b1) lows++;
      tick();
    end
    check("t5_held", 32'(lows), 32'd0);
    check("t5_level2", 32'(bus.level_o), 32'd2);
    cts_n_i = 1'b0;
    wait_low("t5a_start", 6);
    cts_n_i = 1'b1;
    run_frame("t5a", 16'h0278, 10, 2);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_o !== 1'b1) lows++;
      tick();
    end
    check("t5_wait", 32'(lows), 32'd0);
    check("t5_level1", 32'(bus.level_o), 32'd1);
    cts_n_i = 1'b0;
    wait_low("t5b_start", 6);
    run_frame("t5b", 16'h0386, 10, 2);

    // T6: reset during DATA
    bus.baud_div_i = 16'd4;
    push(8'h0F);
    push(8'hF0);
    wait_low("t6_start", 6);
    for (int i = 0; i < 8; i++) tick();
    check("t6_in_frame", 32'(bus.busy_o), 32'd1);
    #3 rst_i = 1'b1;
    #1;
    check("t6_tx", 32'(tx_o), 32'd1);
    check("t6_busy", 32'(bus.busy_o), 32'd0);
    check("t6_empty", 32'(bus.empty_o), 32'd1);
    check("t6_level", 32'(bus.level_o), 32'd0);
    tick();
    rst_i = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_o !== 1'b1 || bus.busy_o !== 1'b0) lows++;
      tick();
    end
    check("t6_quiet", 32'(lows), 32'd0);
    push(8'h55);
    wait_low("t6_new_start", 6);
    run_frame("t6", 16'h02AA, 10, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
